// File: rtl/adc_sequencer.sv
// adc_sequencer: sclk generation, round sequencing and per-channel
// averaging around the ADC SPI master.
module adc_sequencer #(
  parameter int CLK_DIV       = 8,
  parameter int START_SCLKS   = 2,
  parameter int TIMEOUT_SCLKS = 24,
  parameter int ROUND_SCLKS   = 32,
  parameter int AVG_LOG2      = 2,
  parameter int DUAL          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ncs,
  input  logic [9:0] voltage,
  output logic       sclk,
  output logic       start,
  output logic       channel,
  output logic [9:0] ch0_avg,
  output logic [9:0] ch1_avg,
  output logic       ch0_valid,
  output logic       ch1_valid,
  output logic       frame_err
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(ROUND_SCLKS + 1);
  localparam int AW = 10 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int NS = 1 << AVG_LOG2;

  localparam logic [DW-1:0] DIV_END_C = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] START_C   = RW'(START_SCLKS);
  localparam logic [RW-1:0] TMO_C     = RW'(TIMEOUT_SCLKS);
  localparam logic [RW-1:0] ROUND_C   = RW'(ROUND_SCLKS);
  localparam logic [CW-1:0] FULL_C    = CW'(NS);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LAUNCH,
    S_CONVERT,
    S_GAP
  } state_t;

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          div_end;
  logic          sclk_rise;

  logic ncs_s1_q, ncs_s2_q, ncs_s3_q;
  logic ncs_rise;

  state_t        state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [RW-1:0] rnd_inc;
  logic          seen_low_q, seen_low_d;
  logic          chan_q, chan_d;
  logic          capture;
  logic          timeout;

  logic [AW-1:0] acc0_q, acc0_d;
  logic [AW-1:0] acc1_q, acc1_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [9:0]    avg0_q, avg0_d;
  logic [9:0]    avg1_q, avg1_d;
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;
  logic          ferr_q, ferr_d;

  logic [AW-1:0] sum;
  logic [CW-1:0] cnt_inc;
  logic          full;

  assign div_end   = (div_q == DIV_END_C);
  assign sclk_rise = div_end & ~sclk_q;
  assign ncs_rise  = ncs_s2_q & ~ncs_s3_q;
  assign rnd_inc   = rnd_q + 1'b1;

  // Free-running divider: sclk toggles every CLK_DIV clocks.
  always_comb begin
    div_d  = div_q + 1'b1;
    sclk_d = sclk_q;
    if (div_end) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end
  end

  // Divider, sclk and ncs synchronizer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      sclk_q   <= 1'b0;
      ncs_s1_q <= 1'b0;
      ncs_s2_q <= 1'b0;
      ncs_s3_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      ncs_s1_q <= ncs;
      ncs_s2_q <= ncs_s1_q;
      ncs_s3_q <= ncs_s2_q;
    end
  end

  // Round sequencer: next state, round counter and capture decision.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    seen_low_d = seen_low_q;
    chan_d     = chan_q;
    capture    = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      S_FLUSH: begin
        if (sclk_rise) begin
          rnd_d = rnd_inc;
          if (rnd_inc == ROUND_C) begin
            rnd_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (sclk_rise && enable) begin
          rnd_d      = '0;
          seen_low_d = 1'b0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (sclk_rise) begin
          rnd_d = rnd_inc;
          if (rnd_inc == START_C) begin
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        if (!ncs_s2_q) begin
          seen_low_d = 1'b1;
        end
        if (sclk_rise) begin
          rnd_d = rnd_inc;
        end
        if (ncs_rise && seen_low_q) begin
          capture = 1'b1;
          state_d = S_GAP;
        end else if (sclk_rise && rnd_inc == TMO_C) begin
          timeout = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (sclk_rise) begin
          rnd_d = rnd_inc;
          if (rnd_inc == ROUND_C) begin
            if (DUAL != 0) begin
              chan_d = ~chan_q;
            end
            rnd_d      = '0;
            seen_low_d = 1'b0;
            state_d    = enable ? S_LAUNCH : S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_FLUSH;
        rnd_d   = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FLUSH;
      rnd_q      <= '0;
      seen_low_q <= 1'b0;
      chan_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      seen_low_q <= seen_low_d;
      chan_q     <= chan_d;
    end
  end

  assign sum     = (chan_q ? acc1_q : acc0_q) + AW'(voltage);
  assign cnt_inc = (chan_q ? cnt1_q : cnt0_q) + 1'b1;
  assign full    = (cnt_inc == FULL_C);

  // Accumulate captured samples; publish the average on a full block.
  always_comb begin
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    avg0_d = avg0_q;
    avg1_d = avg1_q;
    v0_d   = 1'b0;
    v1_d   = 1'b0;
    ferr_d = timeout;
    if (capture && !chan_q) begin
      if (full) begin
        avg0_d = sum[AW-1:AVG_LOG2];
        acc0_d = '0;
        cnt0_d = '0;
        v0_d   = 1'b1;
      end else begin
        acc0_d = sum;
        cnt0_d = cnt_inc;
      end
    end
    if (capture && chan_q) begin
      if (full) begin
        avg1_d = sum[AW-1:AVG_LOG2];
        acc1_d = '0;
        cnt1_d = '0;
        v1_d   = 1'b1;
      end else begin
        acc1_d = sum;
        cnt1_d = cnt_inc;
      end
    end
  end

  // Accumulator, average and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc0_q <= '0;
      acc1_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      avg0_q <= '0;
      avg1_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      avg0_q <= avg0_d;
      avg1_q <= avg1_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      ferr_q <= ferr_d;
    end
  end

  assign sclk      = sclk_q;
  assign start     = (state_q == S_LAUNCH);
  assign channel   = chan_q;
  assign ch0_avg   = avg0_q;
  assign ch1_avg   = avg1_q;
  assign ch0_valid = v0_q;
  assign ch1_valid = v1_q;
  assign frame_err = ferr_q;

endmodule
